// File: rtl/servo_pulse_decoder.sv
// Servo PWM high-time decoder: measures each pulse and converts it to a 0..MAX_STEPS position code.
// Optional build macro SERVO_DECODE_FILTER_EN adds a 3-cycle stability filter after the synchronizer.
module servo_pulse_decoder #(
  parameter int unsigned MIN_CNT       = 100000,
  parameter int unsigned STEP_CNT      = 555,
  parameter int unsigned MAX_STEPS     = 180,
  parameter int unsigned GLITCH_CNT    = 50000,
  parameter int unsigned MAX_PULSE_CNT = 250000,
  parameter int unsigned TIMEOUT_CNT   = 6000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PWM_IN,
  output logic [7:0] POSITION,
  output logic       VALID,
  output logic       LOCKED,
  output logic       ERR
);

  localparam int unsigned WW = ($clog2(MAX_PULSE_CNT + 3) > 18) ? $clog2(MAX_PULSE_CNT + 3) : 18;
  localparam int unsigned TW = 23;
  localparam int unsigned IW = $clog2(MAX_STEPS + 1);

  localparam logic [WW-1:0] ONE_W    = WW'(1);
  localparam logic [WW-1:0] MIN_W    = WW'(MIN_CNT);
  localparam logic [WW-1:0] STEP_W   = WW'(STEP_CNT);
  localparam logic [WW-1:0] GLITCH_W = WW'(GLITCH_CNT);
  localparam logic [WW-1:0] MAXP_W   = WW'(MAX_PULSE_CNT);
  localparam logic [WW-1:0] WSAT_W   = WW'(MAX_PULSE_CNT + 1);
  localparam logic [TW-1:0] TO_W     = TW'(TIMEOUT_CNT);
  localparam logic [7:0]    MAXS_Q   = 8'(MAX_STEPS);
  localparam logic [IW-1:0] LAST_IT  = IW'(MAX_STEPS - 1);

  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, HIGH} cap_state_t;
  typedef enum logic [1:0] {CV_IDLE, CV_RUN, CV_DONE} cv_state_t;

  logic          sync1, sync2, pwm_s, pwm_d;
  logic          rise, fall;
  logic [2:0]    prime_cnt;
  logic          primed;
  cap_state_t    cap_state;
  logic [WW-1:0] width_cnt, width_meas, rem_init;
  logic          fall_judge, width_bad, start, discard, width_err, done, timeout_hit;
  cv_state_t     cv_state;
  logic [WW-1:0] rem;
  logic [7:0]    quot;
  logic [IW-1:0] iter;
  logic [TW-1:0] tcnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= PWM_IN;
      sync2 <= sync1;
    end
  end

`ifdef SERVO_DECODE_FILTER_EN
  localparam int unsigned PRIME_CYC = 6;
  logic       pwm_f;
  logic [1:0] stab_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pwm_f    <= 1'b0;
      stab_cnt <= '0;
    end else if (sync2 == pwm_f) begin
      stab_cnt <= '0;
    end else if (stab_cnt == 2'd2) begin
      pwm_f    <= sync2;
      stab_cnt <= '0;
    end else begin
      stab_cnt <= stab_cnt + 2'd1;
    end
  end

  assign pwm_s = pwm_f;
`else
  localparam int unsigned PRIME_CYC = 3;
  assign pwm_s = sync2;
`endif

  // The conditioning pipeline resets to 0, so pwm_s is only trusted once it has
  // been refilled from the pin; otherwise a line already high at release would
  // look like a fresh rise and a partial pulse would be measured.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prime_cnt <= '0;
      pwm_d     <= 1'b0;
    end else begin
      pwm_d <= pwm_s;
      if (!primed) prime_cnt <= prime_cnt + 3'd1;
    end
  end

  assign primed = (prime_cnt == 3'(PRIME_CYC));
  assign rise   = pwm_s & ~pwm_d;
  assign fall   = ~pwm_s & pwm_d;

  // The counter excludes the rise cycle, so the fall cycle adds it back.
  assign width_meas  = width_cnt + ONE_W;
  assign width_bad   = (width_meas < GLITCH_W) || (width_meas > MAXP_W);
  assign rem_init    = (width_meas < MIN_W) ? '0 : (width_meas - MIN_W);
  assign fall_judge  = (cap_state == HIGH) && fall;
  assign start       = fall_judge && !width_bad && (cv_state == CV_IDLE);
  assign discard     = fall_judge && !width_bad && (cv_state != CV_IDLE);
  assign width_err   = fall_judge && width_bad;
  assign done        = (cv_state == CV_DONE);
  assign timeout_hit = (tcnt == TO_W);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cap_state <= WAIT_LOW;
      width_cnt <= '0;
    end else begin
      unique case (cap_state)
        WAIT_LOW:  if (primed && !pwm_s) cap_state <= WAIT_RISE;
        WAIT_RISE: if (rise) begin
          width_cnt <= '0;
          cap_state <= HIGH;
        end
        HIGH: begin
          if (fall) cap_state <= WAIT_RISE;
          else if (width_cnt != WSAT_W) width_cnt <= width_cnt + ONE_W;
        end
        default: cap_state <= WAIT_LOW;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cv_state <= CV_IDLE;
      rem      <= '0;
      quot     <= '0;
      iter     <= '0;
    end else begin
      unique case (cv_state)
        CV_IDLE: if (start) begin
          rem      <= rem_init;
          quot     <= '0;
          iter     <= '0;
          cv_state <= CV_RUN;
        end
        CV_RUN: begin
          if ((rem >= STEP_W) && (quot < MAXS_Q)) begin
            rem  <= rem - STEP_W;
            quot <= quot + 8'd1;
          end
          if (iter == LAST_IT) cv_state <= CV_DONE;
          else iter <= iter + IW'(1);
        end
        CV_DONE: cv_state <= CV_IDLE;
        default: cv_state <= CV_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tcnt <= '0;
    end else if (rise) begin
      tcnt <= '0;
    end else if (!timeout_hit) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      POSITION <= '0;
      VALID    <= 1'b0;
      LOCKED   <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      VALID <= done;
      ERR   <= width_err || discard;
      if (done) POSITION <= quot;
      // Any error coinciding with a completion keeps the completion from locking.
      if (width_err || timeout_hit) LOCKED <= 1'b0;
      else if (done && !discard)    LOCKED <= 1'b1;
    end
  end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Scoreboard bench for servo_pulse_decoder with scaled-down timing parameters.
module tb_servo_pulse_decoder;

  localparam int unsigned P_MIN    = 1000;
  localparam int unsigned P_STEP   = 5;
  localparam int unsigned P_MAX    = 180;
  localparam int unsigned P_GLITCH = 100;
  localparam int unsigned P_MAXP   = 2500;
  localparam int unsigned P_TO     = 6000;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       PWM_IN = 1'b0;
  logic [7:0] POSITION;
  logic       VALID, LOCKED, ERR;

  servo_pulse_decoder #(
    .MIN_CNT      (P_MIN),
    .STEP_CNT     (P_STEP),
    .MAX_STEPS    (P_MAX),
    .GLITCH_CNT   (P_GLITCH),
    .MAX_PULSE_CNT(P_MAXP),
    .TIMEOUT_CNT  (P_TO)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .PWM_IN  (PWM_IN),
    .POSITION(POSITION),
    .VALID   (VALID),
    .LOCKED  (LOCKED),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    int unsigned at;
    logic [7:0]  pos;
    bit          lck;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_pos = '0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic match(input bit is_err);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s actual=strobe required=none cycle=%0d pos=%0d", is_err ? "err" : "valid", cyc, POSITION);
    end else begin
      e = sb.pop_front();
      if (e.is_err != is_err || e.at != cyc || POSITION !== e.pos || LOCKED !== e.lck) begin
        errors++;
        $display("FAIL event actual(err=%0d cyc=%0d pos=%0d lck=%0d) required(err=%0d cyc=%0d pos=%0d lck=%0d)",
                 is_err, cyc, POSITION, LOCKED, e.is_err, e.at, e.pos, e.lck);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (VALID === 1'b1) match(1'b0);
      if (ERR === 1'b1)   match(1'b1);
    end
  end

  task automatic pulse(input int unsigned n, output int unsigned fall_at);
    @(posedge CLK); #1 PWM_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1 PWM_IN = 1'b0;
    fall_at = cyc;
  endtask

  task automatic push_valid(input int unsigned f, input logic [7:0] pos);
    sb.push_back('{is_err: 1'b0, at: f + P_MAX + 4, pos: pos, lck: 1'b1});
  endtask

  task automatic push_err(input int unsigned f, input logic [7:0] pos, input bit lck);
    sb.push_back('{is_err: 1'b1, at: f + 3, pos: pos, lck: lck});
  endtask

  task automatic good(input int unsigned n, input logic [7:0] pos);
    int unsigned f;
    pulse(n, f);
    push_valid(f, pos);
    exp_pos = pos;
    repeat (250) @(posedge CLK);
  endtask

  task automatic bad(input int unsigned n);
    int unsigned f;
    pulse(n, f);
    push_err(f, exp_pos, 1'b0);
    repeat (250) @(posedge CLK);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned f1, f2, rise_at, target;

    #2 RST_N = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("rst_position", POSITION, 0);
    check("rst_valid", VALID, 0);
    check("rst_locked", LOCKED, 0);
    check("rst_err", ERR, 0);
    @(posedge CLK); #1 RST_N = 1'b1;
    repeat (10) @(posedge CLK);

    good(1000, 8'd0);
    good(1450, 8'd90);
    good(1454, 8'd90);
    good(1005, 8'd1);
    good(1004, 8'd0);
    good(2200, 8'd180);
    bad(2600);
    good(1450, 8'd90);
    bad(80);
    good(100, 8'd0);
    bad(99);
    good(2500, 8'd180);
    bad(2501);
    good(1450, 8'd90);

    // second pulse ends while the first is still converting
    pulse(1000, f1);
    repeat (20) @(posedge CLK);
    pulse(120, f2);
    push_err(f2, 8'd90, 1'b1);
    push_valid(f1, 8'd0);
    exp_pos = 8'd0;
    repeat (250) @(posedge CLK);

    // lock loss after the input stays low
    pulse(1450, f1);
    push_valid(f1, 8'd90);
    rise_at = f1 - 1450;
    target = rise_at + P_TO + 3;
    while (cyc < target) @(negedge CLK);
    check("locked_before_timeout", LOCKED, 1);
    @(negedge CLK);
    check("locked_after_timeout", LOCKED, 0);
    check("position_after_timeout", POSITION, 90);

    // reset 50 cycles into a conversion, released with the input high
    pulse(1450, f1);
    repeat (52) @(posedge CLK);
    #1 RST_N = 1'b0;
    PWM_IN = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("midconv_position", POSITION, 0);
    check("midconv_valid", VALID, 0);
    check("midconv_locked", LOCKED, 0);
    check("midconv_err", ERR, 0);
    @(posedge CLK); #1 RST_N = 1'b1;
    repeat (1500) @(posedge CLK);
    #1 PWM_IN = 1'b0;
    repeat (400) @(posedge CLK);
    check("no_partial_measure", LOCKED, 0);
    exp_pos = 8'd0;
    good(1450, 8'd90);

    repeat (100) @(posedge CLK);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
